// File: rtl/float_argmax_seq.sv
// float_argmax_seq: sequential argmax over a packed vector of N IEEE-754
// single-precision values. One element is examined per clock; the winning
// index and its raw bits are published together with a one-cycle done pulse.
//
// Handshake: start is only looked at while busy is low. The edge that samples
// start=1 in IDLE snapshots `in` and raises busy. Exactly N edges later done
// pulses for one cycle with index/max_val updated and busy low. start while
// busy is dropped, never queued. rst aborts a scan with no done pulse.
//
// Parameter constraint: 2**IDX_W must be >= N so the counter can address
// every element.
module float_argmax_seq #(
  parameter int N     = 10,
  parameter int IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [32*N-1:0]     in,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    index,
  output logic [31:0]         max_val
);

  // FSM encoding
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  // Counter value of the final element in a scan
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  // State and datapath registers
  logic [0:0]        state_q,    state_d;
  logic [IDX_W-1:0]  cnt_q,      cnt_d;
  logic [32*N-1:0]   buf_q,      buf_d;
  logic [31:0]       best_val_q, best_val_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [IDX_W-1:0]  index_q,    index_d;
  logic [31:0]       max_val_q,  max_val_d;
  logic              done_q,     done_d;

  // Element currently under examination and comparator result
  logic [31:0]       elem;
  logic              elem_gt_best;
  logic              take_elem;
  logic              is_last;

  // Strict IEEE-754 greater-than on raw bits. NaN never wins, any ordinary
  // value beats a NaN, signed zeros are equal, infinities behave as the
  // extreme magnitudes they encode.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    logic a_nan;
    logic b_nan;
    logic both_zero;
    logic res;
    a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    if (a_nan) begin
      res = 1'b0;
    end else if (b_nan) begin
      res = 1'b1;
    end else if (both_zero) begin
      res = 1'b0;
    end else if (a[31] != b[31]) begin
      res = ~a[31];
    end else if (!a[31]) begin
      res = (a[30:0] > b[30:0]);
    end else begin
      res = (a[30:0] < b[30:0]);
    end
    return res;
  endfunction

  // Select buffered element cnt_q without a variable part-select
  always_comb begin
    elem = 32'd0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == IDX_W'(i)) begin
        elem = buf_q[32*i +: 32];
      end
    end
  end

  // Comparator and scan-position decode
  always_comb begin
    elem_gt_best = fp_gt(elem, best_val_q);
    is_last      = (cnt_q == LAST);
    // First element seeds the best unconditionally; later ones only on a
    // strict win, so ties keep the lowest index.
    take_elem    = (cnt_q == '0) || elem_gt_best;
  end

  // Next-state logic for the IDLE/SCAN controller and datapath
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    index_d    = index_q;
    max_val_d  = max_val_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          buf_d   = in;
          cnt_d   = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (take_elem) begin
          best_val_d = elem;
          best_idx_d = cnt_q;
        end
        cnt_d = cnt_q + IDX_W'(1);
        if (is_last) begin
          // Publish the best including the element examined this cycle
          index_d   = best_idx_d;
          max_val_d = best_val_d;
          done_d    = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Register update with synchronous reset that also aborts a running scan
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      buf_q      <= '0;
      best_val_q <= 32'd0;
      best_idx_q <= '0;
      index_q    <= '0;
      max_val_q  <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      index_q    <= index_d;
      max_val_q  <= max_val_d;
      done_q     <= done_d;
    end
  end

  assign busy    = (state_q == S_SCAN);
  assign done    = done_q;
  assign index   = index_q;
  assign max_val = max_val_q;

endmodule

// File: tb/tb_float_argmax_seq.sv
// Directed testbench for float_argmax_seq. Inputs change 1 ns after a rising
// edge; outputs are checked at that same point, reflecting the edge just taken.
module tb_float_argmax_seq;

  localparam int N     = 10;
  localparam int IDX_W = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic                start = 1'b0;
  logic [32*N-1:0]     in_vec = '0;
  logic                busy;
  logic                done;
  logic [IDX_W-1:0]    index;
  logic [31:0]         max_val;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [32*N-1:0] vec;

  float_argmax_seq #(.N(N), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in      (in_vec),
    .busy    (busy),
    .done    (done),
    .index   (index),
    .max_val (max_val)
  );

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32*N-1:0] fill(input logic [31:0] v);
    logic [32*N-1:0] r;
    for (int i = 0; i < N; i++) r[32*i +: 32] = v;
    return r;
  endfunction

  // Start a scan of v, then check busy/done every edge up to completion
  task automatic run_scan(input string tag, input logic [32*N-1:0] v,
                          input int exp_idx, input logic [31:0] exp_val);
    in_vec = v;
    start  = 1'b1;
    step();                                  // edge k
    start  = 1'b0;
    check({tag, "_busy_k"}, 32'(busy), 32'd1);
    for (int i = 1; i < N; i++) begin
      step();
      check({tag, "_busy_mid"}, 32'(busy), 32'd1);
      check({tag, "_nodone_mid"}, 32'(done), 32'd0);
    end
    step();                                  // edge k+N
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_index"}, 32'(index), 32'(exp_idx));
    check({tag, "_max_val"}, max_val, exp_val);
    step();                                  // edge k+N+1
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_index_hold"}, 32'(index), 32'(exp_idx));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_index", 32'(index), 32'd0);
    check("rst_max_val", max_val, 32'd0);
    step();
    check("idle_done", 32'(done), 32'd0);

    // Softmax-like vector
    vec = fill(32'h3D000000);
    vec[32*7 +: 32] = 32'h3F333333;
    run_scan("softmax", vec, 7, 32'h3F333333);

    // Positive tie: lowest index wins
    vec = fill(32'h3F000000);
    vec[32*2 +: 32] = 32'h3F800000;
    vec[32*5 +: 32] = 32'h3F800000;
    run_scan("tie", vec, 2, 32'h3F800000);

    // Signed-zero tie
    vec = fill(32'hBF800000);
    vec[32*0 +: 32] = 32'h80000000;
    vec[32*1 +: 32] = 32'h00000000;
    run_scan("zero_tie", vec, 0, 32'h80000000);

    // All negative
    vec = fill(32'hC0000000);
    vec[32*0 +: 32] = 32'hBF800000;
    run_scan("neg", vec, 0, 32'hBF800000);

    // Smallest positive denormal beats negatives
    vec[32*9 +: 32] = 32'h00000001;
    run_scan("denorm", vec, 9, 32'h00000001);

    // NaN loses, +Inf wins
    vec = fill(32'h3F800000);
    vec[32*0 +: 32] = 32'h7FC00000;
    vec[32*3 +: 32] = 32'h7F800000;
    run_scan("nan_inf", vec, 3, 32'h7F800000);

    // All NaN
    run_scan("all_nan", fill(32'h7FC00000), 0, 32'h7FC00000);

    // Isolation and ignored start while busy
    vec = fill(32'h3F000000);
    vec[32*4 +: 32] = 32'h40000000;
    in_vec = vec;
    start  = 1'b1;
    step();                                  // edge k
    start  = 1'b0;
    vec = fill(32'h3F000000);
    vec[32*1 +: 32] = 32'h40400000;
    in_vec = vec;                            // changed after snapshot
    step();                                  // k+1
    step();                                  // k+2
    start = 1'b1;
    step();                                  // k+3: ignored
    start = 1'b0;
    check("iso_busy_k3", 32'(busy), 32'd1);
    for (int i = 4; i < N; i++) begin
      step();
      check("iso_nodone_mid", 32'(done), 32'd0);
    end
    step();                                  // k+10
    check("iso_done", 32'(done), 32'd1);
    check("iso_index", 32'(index), 32'd4);
    check("iso_max_val", max_val, 32'h40000000);
    start = 1'b1;
    step();                                  // k+11: restart accepted
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("iso_no_second_done", 32'(done), 32'd0);
    for (int i = 12; i < 21; i++) begin
      step();
      check("restart_nodone", 32'(done), 32'd0);
    end
    step();                                  // k+21
    check("restart_done", 32'(done), 32'd1);
    check("restart_index", 32'(index), 32'd1);
    check("restart_max_val", max_val, 32'h40400000);
    step();

    // Reset mid-scan
    vec = fill(32'h3F000000);
    vec[32*6 +: 32] = 32'h3F400000;
    in_vec = vec;
    start  = 1'b1;
    step();                                  // edge k
    start  = 1'b0;
    for (int i = 1; i < 5; i++) step();      // k+1..k+4
    rst = 1'b1;
    step();                                  // k+5
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_index", 32'(index), 32'd0);
    check("midrst_max_val", max_val, 32'd0);
    for (int i = 6; i <= 15; i++) begin
      step();
      check("midrst_nodone", 32'(done), 32'd0);
      check("midrst_idle", 32'(busy), 32'd0);
    end

    // Fresh scan after reset
    run_scan("post_rst", vec, 6, 32'h3F400000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
